stack_sequencer: RTL and testbench
==================================

// Module: stack_sequencer
// PURPOSE
//  Sequences the 3-nibble PC stack transfers between the CPU core and work RAM page 0.
//  Used by CALL/CALZ (push) and RET/RETS/RETD (pop).
//  Owns the RAM port for the whole transfer and returns the popped PC to the core.
//  Returns the new SP to the core; the core applies it on done.
// PARAMETERS
//  RAM_PAGE   4'h0  upper address nibble of the stack page (ram_addr[11:8])
// PORTS
//  clk         in   1   system clock
//  reset_n     in   1   asynchronous active-low reset
//  clk_en      in   1   CPU clock enable; state advances only when 1
//  start_push  in   1   request push of push_pc (sampled in IDLE)
//  start_pop   in   1   request pop into pop_pc (sampled in IDLE)
//  pop_inc     in   1   RETS: add 1 to popped PCS (sampled with start_pop)
//  push_pc     in   12  {PCP[11:8], PCSH[7:4], PCSL[3:0]} to push
//  sp_in       in   8   current SP
//  ram_rdata   in   4   RAM read data; valid the enabled cycle after ram_addr
//  ram_addr    out  12  RAM nibble address {RAM_PAGE, sp_offset}
//  ram_we      out  1   RAM write strobe
//  ram_wdata   out  4   RAM write data
//  busy        out  1   1 in any state other than IDLE
//  done        out  1   1-enabled-cycle completion pulse
//  pop_pc      out  12  popped {PCP, PCSH, PCSL}; valid while done=1, held after
//  sp_out      out  8   updated SP; valid while done=1
//  sp_we       out  1   equals done; core loads sp_out into SP
// BEHAVIOUR
//  Reset values
//   - State IDLE; all outputs 0.
//   - Reset asserted mid-transfer aborts it: no done pulse, no sp_we, writes already
//     issued are not undone.
//  clk_en = 0
//   - State, latches and outputs are frozen.
//   - ram_we is forced 0 so a stalled write never repeats.
//  Start sampling (IDLE, clk_en = 1)
//   - start_push has priority over start_pop when both are 1.
//   - Latches sp_in as SP0; latches push_pc or pop_inc.
//   - Starts while busy are ignored.
//  States: IDLE, PUSH0, PUSH1, PUSH2, POP0, POP1, POP2, POP3, DONE.
//  Push (SP0 - 1, SP0 - 2, SP0 - 3, 8-bit wrap)
//   - IDLE->PUSH0: we=1, addr=SP0-1, wdata=PCP.
//   - PUSH1: we=1, addr=SP0-2, wdata=PCSH.
//   - PUSH2: we=1, addr=SP0-3, wdata=PCSL.
//   - DONE: done=1, sp_out=SP0-3.
//   - Latency: done in the 4th enabled cycle after the start cycle.
//  Pop (SP0, SP0 + 1, SP0 + 2, 8-bit wrap)
//   - POP0: addr=SP0.
//   - POP1: addr=SP0+1; capture rdata as PCSL.
//   - POP2: addr=SP0+2; capture PCSH.
//   - POP3: capture PCP; ram_addr holds SP0+2.
//   - DONE: done=1, sp_out=SP0+3.
//   - pop_pc = {PCP, PCSH, PCSL}.
//   - If pop_inc: PCS = PCS + 1 with 8-bit wrap; PCP is unchanged (0x7FF -> 0x700).
//   - Latency: done in the 5th enabled cycle after the start cycle.
//  DONE -> IDLE on the next enabled cycle.
//   - A start may be sampled in the IDLE cycle that follows (back-to-back allowed).
//  ram_we = 0 in every state except PUSH0..PUSH2.
//  ram_addr, ram_wdata = 0 in IDLE.
//  Stack page wrap: addresses wrap within the 256-nibble page.
//   - Never carry into ram_addr[11:8].
// TESTING
//  1. ram[044]=D, [045]=4, [046]=7; sp_in=44, start_pop
//     -> pop_pc=74D, sp_out=47, done in the 5th enabled cycle, ram_we never 1.
//  2. Same RAM contents with pop_inc=1 -> pop_pc=74E.
//     ram[044]=F, [045]=F, [046]=3 with pop_inc=1 -> pop_pc=300.
//  3. push_pc=123, sp_in=44, start_push
//     -> writes [043]=1, [042]=2, [041]=3 in order; sp_out=41; done in the 4th enabled cycle.
//  4. push_pc=ABC, sp_in=01 -> writes [000]=A, [0FF]=B, [0FE]=C; sp_out=FE.
//     Pop with sp_in=FE -> reads FE, FF, 00; sp_out=01.
//  5. clk_en toggled 1/0 every cycle during a push -> same three writes exactly once
//     each; done lasts one enabled cycle.
//  6. Remaining checks:
//     - start_push and start_pop both 1 -> push performed.
//     - Drop reset_n in PUSH1 -> outputs 0, no done/sp_we; next start_pop completes normally.

Source files
------------

// File: rtl/stack_sequencer_if.sv
// Core/RAM-side signal bundle for the PC stack sequencer.
// The sequencer takes the slave view; the core, together with its RAM port, takes the master view.
interface stack_sequencer_if;
    logic        clk_en;
    logic        start_push;
    logic        start_pop;
    logic        pop_inc;
    logic [11:0] push_pc;
    logic [7:0]  sp_in;
    logic [3:0]  ram_rdata;
    logic [11:0] ram_addr;
    logic        ram_we;
    logic [3:0]  ram_wdata;
    logic        busy;
    logic        done;
    logic [11:0] pop_pc;
    logic [7:0]  sp_out;
    logic        sp_we;

    modport slave (
        input  clk_en, start_push, start_pop, pop_inc, push_pc, sp_in, ram_rdata,
        output ram_addr, ram_we, ram_wdata, busy, done, pop_pc, sp_out, sp_we
    );

    modport master (
        output clk_en, start_push, start_pop, pop_inc, push_pc, sp_in, ram_rdata,
        input  ram_addr, ram_we, ram_wdata, busy, done, pop_pc, sp_out, sp_we
    );
endinterface

// File: rtl/stack_sequencer.sv
// Moves a 3-nibble PC between the core and the stack page of work RAM (push or pop),
// owning the RAM port for the whole transfer and handing back the new SP on done.
module stack_sequencer #(
    parameter logic [3:0] RAM_PAGE = 4'h0
) (
    input  logic             clk,
    input  logic             reset_n,
    stack_sequencer_if.slave bus
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_PUSH0 = 4'd1;
    localparam logic [3:0] S_PUSH1 = 4'd2;
    localparam logic [3:0] S_PUSH2 = 4'd3;
    localparam logic [3:0] S_POP0  = 4'd4;
    localparam logic [3:0] S_POP1  = 4'd5;
    localparam logic [3:0] S_POP2  = 4'd6;
    localparam logic [3:0] S_POP3  = 4'd7;
    localparam logic [3:0] S_DONE  = 4'd8;

    logic [3:0]  r_state;
    logic [7:0]  r_sp0;
    logic [11:0] r_pc;      // push source, reused to collect PCSL/PCSH on pop
    logic        r_inc;
    logic        r_pop;
    logic [11:0] r_pop_pc;

    logic [7:0]  w_off;
    logic        w_addr_vld;
    logic        w_we;
    logic [3:0]  w_wdata;
    logic        w_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_sp0    <= 8'h00;
            r_pc     <= 12'h000;
            r_inc    <= 1'b0;
            r_pop    <= 1'b0;
            r_pop_pc <= 12'h000;
        end else if (bus.clk_en) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start_push) begin
                        r_sp0   <= bus.sp_in;
                        r_pc    <= bus.push_pc;
                        r_pop   <= 1'b0;
                        r_state <= S_PUSH0;
                    end else if (bus.start_pop) begin
                        r_sp0   <= bus.sp_in;
                        r_inc   <= bus.pop_inc;
                        r_pop   <= 1'b1;
                        r_state <= S_POP0;
                    end
                end
                S_PUSH0: r_state <= S_PUSH1;
                S_PUSH1: r_state <= S_PUSH2;
                S_PUSH2: r_state <= S_DONE;
                S_POP0:  r_state <= S_POP1;
                S_POP1: begin
                    r_pc[3:0] <= bus.ram_rdata;
                    r_state   <= S_POP2;
                end
                S_POP2: begin
                    r_pc[7:4] <= bus.ram_rdata;
                    r_state   <= S_POP3;
                end
                S_POP3: begin
                    // RETS increment stays inside PCS; PCP never takes the carry
                    r_pop_pc <= {bus.ram_rdata, r_pc[7:0] + {7'd0, r_inc}};
                    r_state  <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_off      = 8'h00;
        w_addr_vld = 1'b0;
        w_we       = 1'b0;
        w_wdata    = 4'h0;
        case (r_state)
            S_PUSH0: begin
                w_off = r_sp0 - 8'd1; w_addr_vld = 1'b1; w_we = 1'b1; w_wdata = r_pc[11:8];
            end
            S_PUSH1: begin
                w_off = r_sp0 - 8'd2; w_addr_vld = 1'b1; w_we = 1'b1; w_wdata = r_pc[7:4];
            end
            S_PUSH2: begin
                w_off = r_sp0 - 8'd3; w_addr_vld = 1'b1; w_we = 1'b1; w_wdata = r_pc[3:0];
            end
            S_POP0: begin
                w_off = r_sp0; w_addr_vld = 1'b1;
            end
            S_POP1: begin
                w_off = r_sp0 + 8'd1; w_addr_vld = 1'b1;
            end
            S_POP2, S_POP3: begin
                w_off = r_sp0 + 8'd2; w_addr_vld = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_done = (r_state == S_DONE);

    // Offset math is 8-bit, so the page nibble is never disturbed by wrap
    assign bus.ram_addr  = w_addr_vld ? {RAM_PAGE, w_off} : 12'h000;
    // A stalled cycle must not repeat the write
    assign bus.ram_we    = w_we & bus.clk_en;
    assign bus.ram_wdata = w_wdata;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = w_done;
    assign bus.sp_we     = w_done;
    assign bus.pop_pc    = r_pop_pc;
    assign bus.sp_out    = !w_done ? 8'h00 : (r_pop ? r_sp0 + 8'd3 : r_sp0 - 8'd3);

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer: nibble RAM model with write log, hand-computed expectations.
module tb_stack_sequencer;

    logic clk;
    logic reset_n;
    int   n_vec;
    int   n_err;

    stack_sequencer_if sif();

    stack_sequencer #(.RAM_PAGE(4'h0)) u_dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Nibble RAM with one-enabled-cycle read latency; every write is logged as {addr, data}
    logic [3:0]  mem [0:4095];
    logic [15:0] wlog [$];

    always @(posedge clk) begin
        if (sif.ram_we) begin
            mem[sif.ram_addr] <= sif.ram_wdata;
            wlog.push_back({sif.ram_addr, sif.ram_wdata});
        end
        if (sif.clk_en) sif.ram_rdata <= mem[sif.ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts an op in the current (IDLE) cycle and runs until done has been seen and busy falls
    task automatic run_op(input logic psh, input logic pp, input logic inc, input logic [11:0] pc,
                          input logic [7:0] sp, input bit tog, output int lat, output int dcnt,
                          output logic [11:0] ppc, output logic [7:0] spo, output int spwe_bad);
        int ecnt;
        sif.clk_en     = 1'b1;
        sif.start_push = psh;
        sif.start_pop  = pp;
        sif.pop_inc    = inc;
        sif.push_pc    = pc;
        sif.sp_in      = sp;
        step();
        sif.start_push = 1'b0;
        sif.start_pop  = 1'b0;
        sif.pop_inc    = 1'b0;
        lat = -1; dcnt = 0; ecnt = 0; ppc = 12'h000; spo = 8'h00; spwe_bad = 0;
        for (int c = 0; c < 40; c++) begin
            if (dcnt > 0 && !sif.busy) break;
            sif.clk_en = tog ? ~sif.clk_en : 1'b1;
            #1;
            if (sif.sp_we !== sif.done) spwe_bad++;
            if (sif.clk_en) begin
                ecnt++;
                if (sif.done) begin
                    dcnt++;
                    if (lat < 0) begin
                        lat = ecnt;
                        ppc = sif.pop_pc;
                        spo = sif.sp_out;
                    end
                end
            end
            step();
        end
        sif.clk_en = 1'b1;
        #1;
    endtask

    task automatic chk_writes(input string tag, input int base, input logic [15:0] w0,
                              input logic [15:0] w1, input logic [15:0] w2);
        logic [15:0] exp [3];
        exp[0] = w0; exp[1] = w1; exp[2] = w2;
        chk({tag, "_nwr"}, wlog.size() - base, 3);
        for (int i = 0; i < 3; i++)
            if (base + i < wlog.size()) chk($sformatf("%s_wr%0d", tag, i), wlog[base + i], exp[i]);
    endtask

    int          lat, dcnt, spwe_bad, base;
    logic [11:0] ppc;
    logic [7:0]  spo;

    initial begin
        n_vec = 0; n_err = 0;
        reset_n = 1'b0;
        sif.clk_en = 1'b0; sif.start_push = 1'b0; sif.start_pop = 1'b0; sif.pop_inc = 1'b0;
        sif.push_pc = 12'h000; sif.sp_in = 8'h00; sif.ram_rdata = 4'h0;
        repeat (3) step();

        chk("rst_busy",  sif.busy, 0);
        chk("rst_done",  sif.done, 0);
        chk("rst_spwe",  sif.sp_we, 0);
        chk("rst_we",    sif.ram_we, 0);
        chk("rst_addr",  sif.ram_addr, 0);
        chk("rst_wdata", sif.ram_wdata, 0);
        chk("rst_poppc", sif.pop_pc, 0);
        chk("rst_spout", sif.sp_out, 0);
        reset_n = 1'b1;
        step();

        // Fill [044..046] = D,4,7 with a push from SP=47
        base = wlog.size();
        run_op(1, 0, 0, 12'h74D, 8'h47, 0, lat, dcnt, ppc, spo, spwe_bad);
        chk_writes("fill", base, 16'h0467, 16'h0454, 16'h044D);
        chk("fill_sp", spo, 8'h44);

        base = wlog.size();
        run_op(0, 1, 0, 12'h000, 8'h44, 0, lat, dcnt, ppc, spo, spwe_bad);
        chk("pop1_pc",   ppc, 12'h74D);
        chk("pop1_sp",   spo, 8'h47);
        chk("pop1_lat",  lat, 5);
        chk("pop1_dcnt", dcnt, 1);
        chk("pop1_nowr", wlog.size() - base, 0);
        chk("pop1_spwe", spwe_bad, 0);
        chk("pop1_hold", sif.pop_pc, 12'h74D);
        chk("pop1_sp0",  sif.sp_out, 8'h00);

        run_op(0, 1, 1, 12'h000, 8'h44, 0, lat, dcnt, ppc, spo, spwe_bad);
        chk("pop2_pc", ppc, 12'h74E);

        // [044..046] = F,F,3 then RETS: PCS wraps, PCP unchanged
        run_op(1, 0, 0, 12'h3FF, 8'h47, 0, lat, dcnt, ppc, spo, spwe_bad);
        run_op(0, 1, 1, 12'h000, 8'h44, 0, lat, dcnt, ppc, spo, spwe_bad);
        chk("pop3_pc", ppc, 12'h300);
        chk("pop3_sp", spo, 8'h47);

        base = wlog.size();
        run_op(1, 0, 0, 12'h123, 8'h44, 0, lat, dcnt, ppc, spo, spwe_bad);
        chk_writes("push1", base, 16'h0431, 16'h0422, 16'h0413);
        chk("push1_sp",   spo, 8'h41);
        chk("push1_lat",  lat, 4);
        chk("push1_dcnt", dcnt, 1);
        chk("push1_spwe", spwe_bad, 0);

        base = wlog.size();
        run_op(1, 0, 0, 12'hABC, 8'h01, 0, lat, dcnt, ppc, spo, spwe_bad);
        chk_writes("pushw", base, 16'h000A, 16'h0FFB, 16'h0FEC);
        chk("pushw_sp", spo, 8'hFE);

        run_op(0, 1, 0, 12'h000, 8'hFE, 0, lat, dcnt, ppc, spo, spwe_bad);
        chk("popw_pc", ppc, 12'hABC);
        chk("popw_sp", spo, 8'h01);

        base = wlog.size();
        run_op(1, 0, 0, 12'h123, 8'h44, 1, lat, dcnt, ppc, spo, spwe_bad);
        chk_writes("tog", base, 16'h0431, 16'h0422, 16'h0413);
        chk("tog_lat",  lat, 4);
        chk("tog_dcnt", dcnt, 1);
        chk("tog_sp",   spo, 8'h41);

        base = wlog.size();
        run_op(1, 1, 0, 12'h5A6, 8'h30, 0, lat, dcnt, ppc, spo, spwe_bad);
        chk_writes("both", base, 16'h02F5, 16'h02EA, 16'h02D6);
        chk("both_sp", spo, 8'h2D);

        // Abort a push in PUSH1 with reset; pop_pc still holds 0xABC before this
        base = wlog.size();
        sif.clk_en = 1'b1; sif.start_push = 1'b1; sif.push_pc = 12'hE91; sif.sp_in = 8'h60;
        step();
        sif.start_push = 1'b0;
        step();
        reset_n = 1'b0;
        #1;
        chk("abort_busy",  sif.busy, 0);
        chk("abort_we",    sif.ram_we, 0);
        chk("abort_addr",  sif.ram_addr, 0);
        chk("abort_wdata", sif.ram_wdata, 0);
        chk("abort_done",  sif.done, 0);
        chk("abort_spwe",  sif.sp_we, 0);
        chk("abort_poppc", sif.pop_pc, 0);
        repeat (3) step();
        chk("abort_nwr", wlog.size() - base, 1);
        chk("abort_done2", sif.done, 0);
        reset_n = 1'b1;
        step();
        run_op(0, 1, 0, 12'h000, 8'h44, 0, lat, dcnt, ppc, spo, spwe_bad);
        chk("post_pc",  ppc, 12'h3FF);
        chk("post_sp",  spo, 8'h47);
        chk("post_lat", lat, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
